// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - prescaled packed-BCD up/down counter with limits, load and status pulses
// Optional parallel load path: define BCD_COUNTER_LOAD_EN.
`timescale 1ns/1ps
module bcd_updown_counter #(
   parameter int DIGITS          = 3,
   parameter int CLOCKS_PER_STEP = 3,
   parameter int MIN_VALUE       = 0,
   parameter int MAX_VALUE       = 12,
   parameter int WRAP            = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  dir,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_bcd,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  updated,
   output logic                  wrapped,
   output logic                  at_limit,
   output logic                  load_err
);
   localparam int W  = 4 * DIGITS;
   localparam int PW = (CLOCKS_PER_STEP > 1) ? $clog2(CLOCKS_PER_STEP) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLOCKS_PER_STEP - 1);

   function automatic logic [W-1:0] to_bcd(input int value);
      logic [W-1:0] r;
      int           v;
      r = '0;
      v = value;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VALUE);
   localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

   // Digit-serial ripple: only digits reached by the carry/borrow change.
   function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (c) begin
            if (up) begin
               if (v[4*k +: 4] == 4'd9) begin
                  r[4*k +: 4] = 4'd0;
               end else begin
                  r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (v[4*k +: 4] == 4'd0) begin
                  r[4*k +: 4] = 4'd9;
               end else begin
                  r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   logic [W-1:0]  bcd_q, bcd_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          updated_q, updated_d;
   logic          wrapped_q, wrapped_d;
   logic          load_err_q, load_err_d;
   logic          at_lim;
   logic          step;

   assign at_lim = dir ? (bcd_q == MAX_BCD) : (bcd_q == MIN_BCD);

`ifdef BCD_COUNTER_LOAD_EN
   logic digits_ok;
   logic load_ok;
   always_comb begin
      digits_ok = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (load_bcd[4*k +: 4] > 4'd9) digits_ok = 1'b0;
      end
   end
   // Packed BCD with valid digits orders the same as its decimal value.
   assign load_ok = digits_ok && (load_bcd >= MIN_BCD) && (load_bcd <= MAX_BCD);
`else
   logic unused_load;
   assign unused_load = ^{load, load_bcd};
`endif

   always_comb begin
      bcd_d      = bcd_q;
      pre_d      = pre_q;
      updated_d  = 1'b0;
      wrapped_d  = 1'b0;
      load_err_d = 1'b0;
      step       = 1'b0;
      if (en) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            step  = 1'b1;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
      if (step) begin
         if (!at_lim) begin
            bcd_d     = bcd_step(bcd_q, dir);
            updated_d = 1'b1;
         end else if (WRAP != 0) begin
            bcd_d     = dir ? MIN_BCD : MAX_BCD;
            wrapped_d = 1'b1;
            updated_d = (bcd_d != bcd_q);
         end
      end
`ifdef BCD_COUNTER_LOAD_EN
      if (load) begin
         wrapped_d = 1'b0;
         if (load_ok) begin
            bcd_d     = load_bcd;
            pre_d     = '0;
            updated_d = (load_bcd != bcd_q);
         end else begin
            bcd_d      = bcd_q;
            pre_d      = pre_q;
            updated_d  = 1'b0;
            load_err_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_q      <= MIN_BCD;
         pre_q      <= '0;
         updated_q  <= 1'b0;
         wrapped_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         bcd_q      <= bcd_d;
         pre_q      <= pre_d;
         updated_q  <= updated_d;
         wrapped_q  <= wrapped_d;
         load_err_q <= load_err_d;
      end
   end

   assign bcd      = bcd_q;
   assign updated  = updated_q;
   assign wrapped  = wrapped_q;
   assign load_err = load_err_q;
   assign at_limit = at_lim;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter (three parameter sets)
`timescale 1ns/1ps
module tb_bcd_updown_counter;
`ifdef BCD_COUNTER_LOAD_EN
   localparam bit LOAD_EN = 1'b1;
`else
   localparam bit LOAD_EN = 1'b0;
`endif
   // Instance 0: defaults; 1: saturating; 2: one clock per step, 5..120.
   localparam int CPS [3]  = '{3, 3, 1};
   localparam int MINV[3]  = '{0, 0, 5};
   localparam int MAXV[3]  = '{12, 12, 120};
   localparam int WRP [3]  = '{1, 0, 1};

   logic        clk;
   logic        rst_s [3];
   logic        en_s  [3];
   logic        dir_s [3];
   logic        load_s[3];
   logic [11:0] ldb_s [3];
   logic [11:0] bcd_s [3];
   logic        upd_s [3];
   logic        wr_s  [3];
   logic        lim_s [3];
   logic        le_s  [3];

   int  m_val[3];
   int  m_pre[3];
   bit  m_upd[3];
   bit  m_wr [3];
   bit  m_le [3];
   int  n_chk;
   int  n_fail;
   bit  chk_on;
   bit  done;

   bcd_updown_counter #(.DIGITS(3), .CLOCKS_PER_STEP(3), .MIN_VALUE(0), .MAX_VALUE(12), .WRAP(1)) u0 (
      .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .dir(dir_s[0]), .load(load_s[0]), .load_bcd(ldb_s[0]),
      .bcd(bcd_s[0]), .updated(upd_s[0]), .wrapped(wr_s[0]), .at_limit(lim_s[0]), .load_err(le_s[0]));
   bcd_updown_counter #(.DIGITS(3), .CLOCKS_PER_STEP(3), .MIN_VALUE(0), .MAX_VALUE(12), .WRAP(0)) u1 (
      .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .dir(dir_s[1]), .load(load_s[1]), .load_bcd(ldb_s[1]),
      .bcd(bcd_s[1]), .updated(upd_s[1]), .wrapped(wr_s[1]), .at_limit(lim_s[1]), .load_err(le_s[1]));
   bcd_updown_counter #(.DIGITS(3), .CLOCKS_PER_STEP(1), .MIN_VALUE(5), .MAX_VALUE(120), .WRAP(1)) u2 (
      .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .dir(dir_s[2]), .load(load_s[2]), .load_bcd(ldb_s[2]),
      .bcd(bcd_s[2]), .updated(upd_s[2]), .wrapped(wr_s[2]), .at_limit(lim_s[2]), .load_err(le_s[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] dec2bcd(input int v);
      return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Decimal value of a packed BCD word, or -1 when any digit is not decimal.
   function automatic int bcd2dec(input logic [11:0] b);
      int v;
      v = 0;
      for (int k = 2; k >= 0; k--) begin
         if (b[4*k +: 4] > 4'd9) return -1;
         v = v * 10 + int'(b[4*k +: 4]);
      end
      return v;
   endfunction

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update();
      int v;
      for (int i = 0; i < 3; i++) begin
         m_upd[i] = 1'b0;
         m_wr[i]  = 1'b0;
         m_le[i]  = 1'b0;
         if (rst_s[i]) begin
            m_val[i] = MINV[i];
            m_pre[i] = 0;
         end else if (LOAD_EN && load_s[i]) begin
            v = bcd2dec(ldb_s[i]);
            if (v >= MINV[i] && v <= MAXV[i]) begin
               m_upd[i] = (v != m_val[i]);
               m_val[i] = v;
               m_pre[i] = 0;
            end else begin
               m_le[i] = 1'b1;
            end
         end else if (en_s[i]) begin
            if (m_pre[i] < CPS[i] - 1) begin
               m_pre[i]++;
            end else begin
               m_pre[i] = 0;
               if (dir_s[i] && m_val[i] < MAXV[i]) begin
                  m_val[i]++;
                  m_upd[i] = 1'b1;
               end else if (!dir_s[i] && m_val[i] > MINV[i]) begin
                  m_val[i]--;
                  m_upd[i] = 1'b1;
               end else if (WRP[i] != 0) begin
                  v = dir_s[i] ? MINV[i] : MAXV[i];
                  m_upd[i] = (v != m_val[i]);
                  m_wr[i]  = 1'b1;
                  m_val[i] = v;
               end
            end
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_inst(input int i);
      rst_s[i] = 1'b1;
      tick(1);
      rst_s[i] = 1'b0;
   endtask

   initial begin
      int wr_cnt;
      int upd_cnt;
      int d;
      n_chk  = 0;
      n_fail = 0;
      chk_on = 1'b0;
      done   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rst_s[i] = 1'b1; en_s[i] = 1'b0; dir_s[i] = 1'b1; load_s[i] = 1'b0; ldb_s[i] = '0;
         m_val[i] = MINV[i]; m_pre[i] = 0; m_upd[i] = 0; m_wr[i] = 0; m_le[i] = 0;
      end
      dir_s[1] = 1'b0;
      fork
         begin
            while (!done) begin
               @(posedge clk);
               model_update();
               #1;
               if (chk_on) begin
                  for (int i = 0; i < 3; i++) begin
                     check($sformatf("m%0d_bcd", i), bcd_s[i], dec2bcd(m_val[i]));
                     check($sformatf("m%0d_updated", i), 12'(upd_s[i]), 12'(m_upd[i]));
                     check($sformatf("m%0d_wrapped", i), 12'(wr_s[i]), 12'(m_wr[i]));
                     check($sformatf("m%0d_load_err", i), 12'(le_s[i]), 12'(m_le[i]));
                     check($sformatf("m%0d_at_limit", i), 12'(lim_s[i]),
                           12'(dir_s[i] ? (m_val[i] == MAXV[i]) : (m_val[i] == MINV[i])));
                  end
               end
            end
         end
         begin
            tick(2);
            chk_on = 1'b1;
            check("reset_bcd0", bcd_s[0], 12'h000);
            check("reset_upd0", 12'(upd_s[0]), 12'h0);
            check("reset_lim0", 12'(lim_s[0]), 12'h0);
            check("reset_bcd2", bcd_s[2], 12'h005);
            check("reset_lim1", 12'(lim_s[1]), 12'h1);

            // Free run of u0 through a full wrap; u1 pinned at its lower limit.
            for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
            en_s[0] = 1'b1;
            en_s[1] = 1'b1;
            wr_cnt  = 0;
            upd_cnt = 0;
            for (int t = 1; t <= 39; t++) begin
               tick(1);
               if (t == 2) check("first_step_not_early", bcd_s[0], 12'h000);
               if (t == 3) check("first_step", bcd_s[0], 12'h001);
               if (t == 6) check("second_step", bcd_s[0], 12'h002);
               if (t == 36) check("at_max", bcd_s[0], 12'h012);
               if (wr_s[0]) wr_cnt++;
               if (upd_s[1]) upd_cnt++;
            end
            check("wrap_value", bcd_s[0], 12'h000);
            check("wrap_count", 12'(wr_cnt), 12'd1);
            check("sat_low_bcd", bcd_s[1], 12'h000);
            check("sat_low_updates", 12'(upd_cnt), 12'd0);
            check("sat_low_lim", 12'(lim_s[1]), 12'h1);
            dir_s[1] = 1'b1;
            tick(2);
            check("sat_dir_up_wait", bcd_s[1], 12'h000);
            tick(1);
            check("sat_dir_up", bcd_s[1], 12'h001);

            // en dropped after two prescaler counts.
            reset_inst(0);
            tick(2);
            check("en_pre2", bcd_s[0], 12'h000);
            en_s[0] = 1'b0;
            tick(5);
            check("en_hold", bcd_s[0], 12'h000);
            en_s[0] = 1'b1;
            tick(1);
            check("en_resume", bcd_s[0], 12'h001);

            // u2: carry and borrow across two digits, wrap down to MAX.
            en_s[2] = 1'b1;
            tick(94);
            check("u2_099", bcd_s[2], 12'h099);
            tick(1);
            check("u2_carry", bcd_s[2], 12'h100);
            dir_s[2] = 1'b0;
            tick(1);
            check("u2_borrow", bcd_s[2], 12'h099);
            tick(94);
            check("u2_min", bcd_s[2], 12'h005);
            tick(1);
            check("u2_wrap_down", bcd_s[2], 12'h120);
            check("u2_wrap_pulse", 12'(wr_s[2]), 12'h1);
            en_s[2] = 1'b0;

            // Loads on u0: bad digit, out of range, then a load on a step edge.
            reset_inst(0);
            tick(1);
            ldb_s[0] = 12'h0A5; load_s[0] = 1'b1;
            tick(1);
            check("load_bad_digit_err", 12'(le_s[0]), LOAD_EN ? 12'h1 : 12'h0);
            check("load_bad_digit_bcd", bcd_s[0], 12'h000);
            ldb_s[0] = 12'h013;
            tick(1);
            check("load_range_err", 12'(le_s[0]), LOAD_EN ? 12'h1 : 12'h0);
            check("load_range_bcd", bcd_s[0], LOAD_EN ? 12'h000 : 12'h001);
            load_s[0] = 1'b0;
            tick(1);
            ldb_s[0] = 12'h007; load_s[0] = 1'b1;
            tick(1);
            load_s[0] = 1'b0;
            check("load_on_step", bcd_s[0], LOAD_EN ? 12'h007 : 12'h001);
            tick(2);
            check("load_pre_restart", bcd_s[0], LOAD_EN ? 12'h007 : 12'h002);
            tick(1);
            check("load_next_step", bcd_s[0], LOAD_EN ? 12'h008 : 12'h002);

            // Reset pulses at random points while u0 counts.
            for (int r = 0; r < 4; r++) begin
               d = int'($urandom_range(620, 60));
               #(d);
               @(negedge clk);
               reset_inst(0);
               check("rst_bcd", bcd_s[0], 12'h000);
               check("rst_upd", 12'(upd_s[0]), 12'h0);
               tick(3);
               check("rst_step1", bcd_s[0], 12'h001);
               tick(3);
               check("rst_step2", bcd_s[0], 12'h002);
            end

            // u1 saturating at the top, then at_limit following dir directly.
            reset_inst(1);
            tick(45);
            check("sat_high_bcd", bcd_s[1], 12'h012);
            check("sat_high_upd", 12'(upd_s[1]), 12'h0);
            check("sat_high_lim", 12'(lim_s[1]), 12'h1);
            dir_s[1] = 1'b0;
            #1;
            check("lim_follows_dir", 12'(lim_s[1]), 12'h0);
            tick(2);
            done = 1'b1;
         end
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
